// File: rtl/mem_access_scheduler.sv
// Data-memory port arbiter: pipeline loads/stores win the port; an idle
// port is used by a post-HALT dump engine that streams every word out.
//
// Ports:
//   i_clock, i_reset      clock, async active-high reset
//   i_halt, i_dump_start  dump request (honoured only while halted)
//   i_pipe_*              MEM-stage read/write request, address, data
//   i_mem_rdata           memory read data, one cycle after o_mem_re
//   o_mem_*               granted address, data and enables
//   i_tx_ready            debug transmitter accepts o_tx_data
//   o_tx_data/o_tx_valid  dumped word and its valid flag
//   o_dump_busy/o_dump_done  dump status, done is a one-cycle pulse
module mem_access_scheduler #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_pipe_read,
  input  logic               i_pipe_write,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  input  logic               i_dump_start,
  input  logic               i_tx_ready,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [NB_ADDR-1:0] count;
  logic               pipe_req;

  assign pipe_req = i_pipe_read | i_pipe_write;

  // Port mux: the pipeline always wins; the dump only reads in ISSUE.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    if (pipe_req) begin
      o_mem_addr  = i_pipe_addr;
      o_mem_wdata = i_pipe_wdata;
      o_mem_re    = i_pipe_read;
      o_mem_we    = i_pipe_write;
    end else if (state == S_ISSUE) begin
      o_mem_addr = count;
      o_mem_re   = 1'b1;
    end
  end

  // Status flags decode straight from state so reset clears them at once.
  assign o_tx_valid  = (state == S_SEND);
  assign o_dump_busy = (state != S_IDLE);
  assign o_dump_done = (state == S_DONE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      count     <= '0;
      o_tx_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_dump_start && i_halt) begin
            state <= S_ISSUE;
            count <= '0;
          end
        end
        S_ISSUE: begin
          if (!pipe_req) state <= S_WAIT;
        end
        S_WAIT: begin
          o_tx_data <= i_mem_rdata;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            // Terminal test before increment: the counter never wraps.
            if (count == {NB_ADDR{1'b1}}) begin
              state <= S_DONE;
            end else begin
              count <= count + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
